// File: rtl/uart_hex_rx.sv
// UART 8N1 receiver feeding a line parser that accepts exactly ten hex characters
// terminated by LF and presents them as a 40-bit value.
module uart_hex_rx #(
    parameter int CLK_FREQ = 200_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [39:0] data,
    output logic        data_valid,
    output logic        line_error,
    output logic        busy
);

    localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST    = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic        rxMeta_q, rxSync_q;
    state_t      state_q, state_d;
    logic [15:0] clkCount_q, clkCount_d;
    logic [2:0]  bitIdx_q, bitIdx_d;
    logic [7:0]  shift_q, shift_d;
    logic        byteStrobe_q, byteStrobe_d;
    logic        frameErr_q, frameErr_d;
    logic [39:0] acc_q, acc_d;
    logic [3:0]  charCount_q, charCount_d;
    logic        lineErr_q, lineErr_d;
    logic [39:0] data_q, data_d;
    logic        isHex;
    logic [3:0]  nibble;

    // Synchronizer resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            clkCount_q   <= '0;
            bitIdx_q     <= '0;
            shift_q      <= '0;
            byteStrobe_q <= 1'b0;
            frameErr_q   <= 1'b0;
            acc_q        <= '0;
            charCount_q  <= '0;
            lineErr_q    <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            clkCount_q   <= clkCount_d;
            bitIdx_q     <= bitIdx_d;
            shift_q      <= shift_d;
            byteStrobe_q <= byteStrobe_d;
            frameErr_q   <= frameErr_d;
            acc_q        <= acc_d;
            charCount_q  <= charCount_d;
            lineErr_q    <= lineErr_d;
            data_q       <= data_d;
        end
    end

    // Bits arrive LSB first, so shifting in from the top leaves bit 0 at the bottom.
    always_comb begin
        state_d      = state_q;
        clkCount_d   = clkCount_q + 16'd1;
        bitIdx_d     = bitIdx_q;
        shift_d      = shift_q;
        byteStrobe_d = 1'b0;
        frameErr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                clkCount_d = '0;
                if (!rxSync_q) state_d = START;
            end
            START: begin
                if (clkCount_q == HALF_LAST) begin
                    clkCount_d = '0;
                    bitIdx_d   = '0;
                    state_d    = rxSync_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clkCount_q == BIT_LAST) begin
                    clkCount_d = '0;
                    shift_d    = {rxSync_q, shift_q[7:1]};
                    bitIdx_d   = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (clkCount_q == BIT_LAST) begin
                    clkCount_d   = '0;
                    state_d      = IDLE;
                    byteStrobe_d = rxSync_q;
                    frameErr_d   = !rxSync_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        isHex  = 1'b1;
        nibble = '0;
        if (shift_q >= 8'h30 && shift_q <= 8'h39)      nibble = 4'(shift_q - 8'h30);
        else if (shift_q >= 8'h41 && shift_q <= 8'h46) nibble = 4'(shift_q - 8'h37);
        else if (shift_q >= 8'h61 && shift_q <= 8'h66) nibble = 4'(shift_q - 8'h57);
        else                                           isHex  = 1'b0;
    end

    // Once a line is flagged bad, hex characters stop shifting so the flag decides the LF outcome.
    always_comb begin
        acc_d       = acc_q;
        charCount_d = charCount_q;
        lineErr_d   = lineErr_q;
        data_d      = data_q;
        data_valid  = 1'b0;
        line_error  = 1'b0;
        if (!rst) begin
            if (frameErr_q) begin
                lineErr_d = 1'b1;
            end else if (byteStrobe_q) begin
                if (shift_q == 8'h0A) begin
                    if (charCount_q == 4'd10 && !lineErr_q) begin
                        data_valid = 1'b1;
                        data_d     = acc_q;
                    end else begin
                        line_error = 1'b1;
                    end
                    acc_d       = '0;
                    charCount_d = '0;
                    lineErr_d   = 1'b0;
                end else if (shift_q != 8'h0D) begin
                    if (!isHex) begin
                        lineErr_d = 1'b1;
                    end else if (!lineErr_q) begin
                        if (charCount_q == 4'd10) begin
                            lineErr_d = 1'b1;
                        end else begin
                            acc_d       = {acc_q[35:0], nibble};
                            charCount_d = charCount_q + 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign data = data_valid ? acc_q : data_q;
    assign busy = (state_q != IDLE);

endmodule

// File: doc/uart_hex_rx.md
UART_HEX_RX -- requirements
Module: uart_hex_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 200_000_000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning serial bit rate; CLKS_PER_BIT = CLK_FREQ / BAUD (integer divide).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-005 SHALL have port rx  input  1  asynchronous UART line, 8N1, idle high.
REQ-006 SHALL have port data  output  40  last successfully received value.
REQ-007 SHALL have port data_valid  output  1  one-cycle pulse, data updated this cycle.
REQ-008 SHALL have port line_error  output  1  one-cycle pulse, malformed line discarded.
REQ-009 SHALL have port busy  output  1  high while the bit FSM is not in IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-011 SHALL implement bit FSM states IDLE, START, DATA, STOP; clk_count at least 16 bits wide.
REQ-012 SHALL, in IDLE, move to START with clk_count=0 on the first cycle rx_s==0.
REQ-013 SHALL, in START, at clk_count==CLKS_PER_BIT/2-1, return to IDLE if rx_s==1 (glitch, no error), else clear clk_count and enter DATA.
REQ-014 SHALL, in DATA, sample rx_s at clk_count==CLKS_PER_BIT-1 (mid-bit), store LSB first into bit 0..7, and enter STOP after bit 7.
REQ-015 SHALL, in STOP, sample rx_s at clk_count==CLKS_PER_BIT-1 and then return to IDLE; rx_s==1 means byte good, rx_s==0 means framing error.
REQ-016 SHALL deliver a good byte to the line parser in the cycle following the stop-bit sample (byte strobe).
REQ-017 SHALL line-parse as follows: '0'-'9', 'A'-'F', 'a'-'f' shift the nibble into a 40-bit accumulator from the right and increment char_count (0..10).
REQ-018 SHALL ignore 0x0D (CR) entirely.
REQ-019 SHALL, on 0x0A (LF) with char_count==10 and no line error flag, load data from the accumulator and pulse data_valid in the same cycle as the byte strobe.
REQ-020 SHALL, on LF with char_count!=10 or the error flag set, pulse line_error, leave data unchanged, and not pulse data_valid.
REQ-021 SHALL set the line error flag on any other byte, on an 11th hex char, or on a framing error; further hex chars then neither shift nor count.
REQ-022 SHALL clear the accumulator, char_count and error flag after every LF, whether the line was good or bad.
REQ-023 SHALL treat an empty line (LF only) as an error: line_error pulses.
REQ-024 SHALL never assert data_valid and line_error in the same cycle.
REQ-025 SHALL hold data between valid lines.

Reset
REQ-026 SHALL, while rst is high, set data=0, data_valid=0, line_error=0, busy=0, the bit FSM to IDLE, and all counters, accumulator and error flag to 0.
REQ-027 SHALL set both synchronizer flops to 1 on reset.
REQ-028 SHALL, on reset asserted mid-byte or mid-line, discard the partial byte/line; the next start bit after rst falls begins a clean line.

Verification
Use CLK_FREQ=1_152_000, BAUD=115200 (CLKS_PER_BIT=10) for all scenarios.
REQ-029 SHALL cover: send "00DEADBEEF\n" -> one data_valid pulse with data=40'h00DEADBEEF, no line_error.
REQ-030 SHALL cover: send "12345abcde\r\n" -> data=40'h12345ABCDE, data_valid pulse.
REQ-031 SHALL cover: send "123\n" then "FFFFFFFFFF\n" -> line_error after first LF with data still 0; data_valid with 40'hFFFFFFFFFF after second.
REQ-032 SHALL cover: send "0123456789A\n" (11 chars) and "01234G6789\n" -> line_error pulse each, data unchanged.
REQ-033 SHALL cover: a byte with stop bit driven 0 inside an otherwise valid line -> line_error at LF; a 3-cycle low glitch on idle rx -> busy returns to 0, no byte strobe.
REQ-034 SHALL cover: rst pulsed mid-character of a line, then a full "0000000001\n" -> data=40'h0000000001, exactly one data_valid, no line_error.
